// File: rtl/dpe_accum_chain_if.sv
// rtl/dpe_accum_chain_if.sv - operand/result stream bundle for dpe_accum_chain
// Carries the o_sat flags only when DPE_SAT_EN is defined.
interface dpe_accum_chain_if #(
  parameter int IDATAW = 8,
  parameter int ODATAW = 32,
  parameter int LANES  = 16,
  parameter int BATCH  = 2
);
  logic [LANES-1:0][IDATAW-1:0] i_data;
  logic                         i_valid;
  logic                         i_ready;
  logic                         i_load;
  logic                         i_last;
  logic [BATCH-1:0][ODATAW-1:0] o_data;
  logic                         o_valid;
  logic                         o_ready;
`ifdef DPE_SAT_EN
  logic [BATCH-1:0]             o_sat;
`endif

  modport master (
    output i_data, i_valid, i_load, i_last, o_ready,
    input  i_ready, o_data, o_valid
`ifdef DPE_SAT_EN
    , input o_sat
`endif
  );

  modport slave (
    input  i_data, i_valid, i_load, i_last, o_ready,
    output i_ready, o_data, o_valid
`ifdef DPE_SAT_EN
    , output o_sat
`endif
  );
endinterface

// File: rtl/dpe_accum_chain.sv
// rtl/dpe_accum_chain.sv - chained B-bank dot-product engine with multi-beat accumulation
// DPE_SAT_EN: saturating accumulation plus per-batch o_sat flags; default wraps.
module dpe_accum_chain #(
  parameter int IDATAW = 8,
  parameter int ODATAW = 32,
  parameter int LANES  = 16,
  parameter int BATCH  = 2
) (
  input logic              clk,
  input logic              rst,
  dpe_accum_chain_if.slave bus
);
  localparam int PW = 2 * IDATAW;

  logic                                    en;
  logic                                    accept;
  logic [BATCH-1:0][LANES-1:0][IDATAW-1:0] bank_q, bank_d;
  logic                                    s1_valid_q, s1_valid_d, s1_last_q, s1_last_d;
  logic [LANES-1:0][IDATAW-1:0]            s1_a_q, s1_a_d;
  logic                                    s2_valid_q, s2_valid_d, s2_last_q, s2_last_d;
  logic [BATCH-1:0][LANES-1:0][PW-1:0]     s2_prod_q, s2_prod_d;
  logic                                    s3_valid_q, s3_valid_d, s3_last_q, s3_last_d;
  logic [BATCH-1:0][ODATAW-1:0]            s3_sum_q, s3_sum_d;
  logic [BATCH-1:0][ODATAW-1:0]            acc_q, acc_d, out_q, out_d;
  logic                                    out_valid_q, out_valid_d;
  logic signed [PW-1:0]                    pa, pb;
  logic [ODATAW-1:0]                       sum, res;
`ifdef DPE_SAT_EN
  logic [BATCH-1:0]                        sat_acc_q, sat_acc_d, sat_out_q, sat_out_d;
  logic [ODATAW:0]                         nxt;
  logic                                    ovf;
`endif

  // A held result with no taker freezes every stage, banks included.
  assign en          = !(out_valid_q && !bus.o_ready);
  assign accept      = bus.i_valid && en;
  assign bus.i_ready = en;
  assign bus.o_data  = out_q;
  assign bus.o_valid = out_valid_q;
`ifdef DPE_SAT_EN
  assign bus.o_sat   = sat_out_q;
`endif

  always_comb begin
    bank_d     = bank_q;
    s1_valid_d = s1_valid_q;
    s1_last_d  = s1_last_q;
    s1_a_d     = s1_a_q;
    s2_valid_d = s2_valid_q;
    s2_last_d  = s2_last_q;
    s2_prod_d  = s2_prod_q;
    s3_valid_d = s3_valid_q;
    s3_last_d  = s3_last_q;
    s3_sum_d   = s3_sum_q;
    acc_d      = acc_q;
    out_d      = out_q;
    pa         = '0;
    pb         = '0;
    sum        = '0;
    res        = '0;
`ifdef DPE_SAT_EN
    sat_acc_d  = sat_acc_q;
    sat_out_d  = sat_out_q;
    nxt        = '0;
    ovf        = 1'b0;
`endif
    if (en) begin
      s1_valid_d = accept && !bus.i_load;
      if (accept && bus.i_load) begin
        bank_d[0] = bus.i_data;
        for (int k = 1; k < BATCH; k++) bank_d[k] = bank_q[k-1];
      end
      if (accept && !bus.i_load) begin
        s1_a_d    = bus.i_data;
        s1_last_d = bus.i_last;
      end

      // Banks are sampled here, so beat order alone decides old vs new operands.
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_last_d = s1_last_q;
        for (int b = 0; b < BATCH; b++) begin
          for (int l = 0; l < LANES; l++) begin
            pa = PW'($signed(s1_a_q[l]));
            pb = PW'($signed(bank_q[b][l]));
            s2_prod_d[b][l] = pa * pb;
          end
        end
      end

      s3_valid_d = s2_valid_q;
      if (s2_valid_q) begin
        s3_last_d = s2_last_q;
        for (int b = 0; b < BATCH; b++) begin
          sum = '0;
          for (int l = 0; l < LANES; l++) sum = sum + ODATAW'($signed(s2_prod_q[b][l]));
          s3_sum_d[b] = sum;
        end
      end

      if (s3_valid_q) begin
        for (int b = 0; b < BATCH; b++) begin
`ifdef DPE_SAT_EN
          nxt = {acc_q[b][ODATAW-1], acc_q[b]} + {s3_sum_q[b][ODATAW-1], s3_sum_q[b]};
          ovf = nxt[ODATAW] ^ nxt[ODATAW-1];
          if (!ovf)             res = nxt[ODATAW-1:0];
          else if (nxt[ODATAW]) res = {1'b1, {(ODATAW-1){1'b0}}};
          else                  res = {1'b0, {(ODATAW-1){1'b1}}};
          if (s3_last_q) begin
            sat_out_d[b] = sat_acc_q[b] | ovf;
            sat_acc_d[b] = 1'b0;
          end else begin
            sat_acc_d[b] = sat_acc_q[b] | ovf;
          end
`else
          res = acc_q[b] + s3_sum_q[b];
`endif
          if (s3_last_q) begin
            out_d[b] = res;
            acc_d[b] = '0;
          end else begin
            acc_d[b] = res;
          end
        end
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    if (en && s3_valid_q && s3_last_q) out_valid_d = 1'b1;
    else if (out_valid_q && bus.o_ready) out_valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_q      <= '0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_a_q      <= '0;
      s2_valid_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      s2_prod_q   <= '0;
      s3_valid_q  <= 1'b0;
      s3_last_q   <= 1'b0;
      s3_sum_q    <= '0;
      acc_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
`ifdef DPE_SAT_EN
      sat_acc_q   <= '0;
      sat_out_q   <= '0;
`endif
    end else begin
      bank_q      <= bank_d;
      s1_valid_q  <= s1_valid_d;
      s1_last_q   <= s1_last_d;
      s1_a_q      <= s1_a_d;
      s2_valid_q  <= s2_valid_d;
      s2_last_q   <= s2_last_d;
      s2_prod_q   <= s2_prod_d;
      s3_valid_q  <= s3_valid_d;
      s3_last_q   <= s3_last_d;
      s3_sum_q    <= s3_sum_d;
      acc_q       <= acc_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
`ifdef DPE_SAT_EN
      sat_acc_q   <= sat_acc_d;
      sat_out_q   <= sat_out_d;
`endif
    end
  end
endmodule

// File: tb/tb_dpe_accum_chain.sv
// tb/tb_dpe_accum_chain.sv - scoreboard bench for dpe_accum_chain
// Expected words are {o_sat, o_data}; o_sat reads as zero without DPE_SAT_EN.
module tb_dpe_accum_chain;
  localparam int IDATAW = 8;
  localparam int ODATAW = 20;
  localparam int LANES  = 16;
  localparam int BATCH  = 2;
  localparam int RW     = BATCH * ODATAW + BATCH;
  localparam longint OMAX = (longint'(1) << (ODATAW - 1)) - 1;
  localparam longint OMIN = -(longint'(1) << (ODATAW - 1));

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dpe_accum_chain_if #(.IDATAW(IDATAW), .ODATAW(ODATAW), .LANES(LANES), .BATCH(BATCH)) bus ();
  dpe_accum_chain #(.IDATAW(IDATAW), .ODATAW(ODATAW), .LANES(LANES), .BATCH(BATCH)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int          compared = 0;
  int          mismatched = 0;
  int          vec[LANES];
  int          mb[BATCH][LANES];
  longint      macc[BATCH];
  bit          msat[BATCH];
  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] got_q[$];

  always @(negedge clk) begin
    if (!rst && bus.o_valid && bus.o_ready) begin
`ifdef DPE_SAT_EN
      got_q.push_back({bus.o_sat, bus.o_data});
`else
      got_q.push_back({{BATCH{1'b0}}, bus.o_data});
`endif
    end
  end

  function automatic longint wrapo(longint v);
    logic signed [ODATAW-1:0] t;
    t = v[ODATAW-1:0];
    return longint'(t);
  endfunction

  task automatic fill(input int v);
    for (int l = 0; l < LANES; l++) vec[l] = v;
  endtask

  task automatic fill_rand();
    for (int l = 0; l < LANES; l++) vec[l] = int'($urandom_range(255)) - 128;
  endtask

  task automatic model_clear();
    for (int b = 0; b < BATCH; b++) begin
      for (int l = 0; l < LANES; l++) mb[b][l] = 0;
      macc[b] = 0;
      msat[b] = 1'b0;
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic model_beat(input bit load, input bit last);
    longint s, t;
    logic [RW-1:0] e;
    e = '0;
    if (load) begin
      for (int b = BATCH - 1; b > 0; b--) mb[b] = mb[b-1];
      for (int l = 0; l < LANES; l++) mb[0][l] = vec[l];
    end else begin
      for (int b = 0; b < BATCH; b++) begin
        s = 0;
        for (int l = 0; l < LANES; l++) s += longint'(vec[l]) * longint'(mb[b][l]);
        t = macc[b] + wrapo(s);
`ifdef DPE_SAT_EN
        if (t > OMAX) begin t = OMAX; msat[b] = 1'b1; end
        else if (t < OMIN) begin t = OMIN; msat[b] = 1'b1; end
`else
        t = wrapo(t);
`endif
        if (last) begin
          e[b*ODATAW +: ODATAW] = t[ODATAW-1:0];
          e[BATCH*ODATAW + b]   = msat[b];
          macc[b] = 0;
          msat[b] = 1'b0;
        end else begin
          macc[b] = t;
        end
      end
      if (last) exp_q.push_back(e);
    end
  endtask

  task automatic drive_beat(input bit load, input bit last);
    int n;
    @(negedge clk);
    bus.i_valid = 1'b1;
    bus.i_load  = load;
    bus.i_last  = last;
    for (int l = 0; l < LANES; l++) bus.i_data[l] = vec[l][IDATAW-1:0];
    #1;
    n = 0;
    while (!bus.i_ready && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!bus.i_ready) begin
      compared++;
      mismatched++;
      $display("FAIL accept_timeout: i_ready=%b required 1", bus.i_ready);
      bus.i_valid = 1'b0;
      return;
    end
    model_beat(load, last);
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
  endtask

  task automatic wait_got(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (got_q.size() >= n) begin ok = 1'b1; return; end
      @(negedge clk);
      #2;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.i_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    #1;
  endtask

  task automatic test_reset();
    bus.i_valid = 1'b0; bus.i_load = 1'b0; bus.i_last = 1'b0; bus.o_ready = 1'b1; bus.i_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_clear();
    #1;
    compared++;
    if (bus.o_valid !== 1'b0) begin mismatched++; $display("FAIL reset_o_valid: got %b required 0", bus.o_valid); end
    compared++;
    if (bus.i_ready !== 1'b1) begin mismatched++; $display("FAIL reset_i_ready: got %b required 1", bus.i_ready); end
    compared++;
    if (bus.o_data !== '0) begin mismatched++; $display("FAIL reset_o_data: got %h required 0", bus.o_data); end
  endtask

  task automatic test_load();
    int n; bit ok; logic [RW-1:0] e, g;
    fill(1); drive_beat(1'b1, 1'b0);
    fill(2); drive_beat(1'b1, 1'b0);
    fill(3); drive_beat(1'b0, 1'b1);
    for (n = 0; n < 20; n++) begin
      @(negedge clk);
      #1;
      if (bus.o_valid) break;
    end
    compared++;
    if (n !== 3) begin mismatched++; $display("FAIL load_latency: o_valid after %0d cycles required 3", n); end
    wait_got(1, ok);
    if (!ok) begin compared++; mismatched++; $display("FAIL load_timeout: results %0d required 1", got_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      compared++;
      if (g !== e) begin mismatched++; $display("FAIL load_result: got %h required %h", g, e); end
      compared++;
      if (g[ODATAW +: ODATAW] !== ODATAW'(48)) begin mismatched++; $display("FAIL load_bank1: got %0d required 48", g[ODATAW +: ODATAW]); end
      compared++;
      if (g[0 +: ODATAW] !== ODATAW'(96)) begin mismatched++; $display("FAIL load_bank0: got %0d required 96", g[0 +: ODATAW]); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_multi_beat();
    bit ok; logic [RW-1:0] e, g;
    fill(1); drive_beat(1'b1, 1'b0); drive_beat(1'b1, 1'b0);
    fill(1);  drive_beat(1'b0, 1'b0);
    fill(-1); drive_beat(1'b0, 1'b0);
    repeat (3) @(negedge clk);
    fill(4);  drive_beat(1'b0, 1'b1);
    wait_got(1, ok);
    if (!ok) begin compared++; mismatched++; $display("FAIL multi_timeout: results %0d required 1", got_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      compared++;
      if (g !== e) begin mismatched++; $display("FAIL multi_result: got %h required %h", g, e); end
      compared++;
      if (g[0 +: ODATAW] !== ODATAW'(64)) begin mismatched++; $display("FAIL multi_value: got %0d required 64", g[0 +: ODATAW]); end
    end
    repeat (10) @(negedge clk);
    #2;
    compared++;
    if (got_q.size() !== 0) begin mismatched++; $display("FAIL multi_once: extra results %0d required 0", got_q.size()); end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_backpressure();
    bit ok; int n; logic [RW-1:0] e, g;
    logic [BATCH*ODATAW-1:0] held;
    @(posedge clk); #1; bus.o_ready = 1'b0;
    fill_rand(); drive_beat(1'b0, 1'b1);
    for (n = 0; n < 20 && !bus.o_valid; n++) begin @(negedge clk); #1; end
    held = bus.o_data;
    fill_rand();
    fork
      drive_beat(1'b0, 1'b1);
      begin
        repeat (4) begin
          @(negedge clk); #2;
          compared++;
          if (bus.i_ready !== 1'b0) begin mismatched++; $display("FAIL stall_i_ready: got %b required 0", bus.i_ready); end
          compared++;
          if (bus.o_data !== held) begin mismatched++; $display("FAIL stall_hold: got %h required %h", bus.o_data, held); end
        end
        @(posedge clk); #1; bus.o_ready = 1'b1;
      end
    join
    wait_got(2, ok);
    if (!ok) begin compared++; mismatched++; $display("FAIL stall_timeout: results %0d required 2", got_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      compared++;
      if (g !== e) begin mismatched++; $display("FAIL stall_result: got %h required %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_interleave();
    bit ok; logic [RW-1:0] e, g;
    fill_rand(); drive_beat(1'b0, 1'b1);
    fill(5);     drive_beat(1'b1, 1'b0);
    fill_rand(); drive_beat(1'b0, 1'b1);
    wait_got(2, ok);
    if (!ok) begin compared++; mismatched++; $display("FAIL inter_timeout: results %0d required 2", got_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      compared++;
      if (g !== e) begin mismatched++; $display("FAIL inter_result: got %h required %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_extremes();
    bit ok; logic [RW-1:0] e, g;
    fill(-128); drive_beat(1'b1, 1'b0); drive_beat(1'b1, 1'b0);
    drive_beat(1'b0, 1'b0); drive_beat(1'b0, 1'b1);
    wait_got(1, ok);
    if (!ok) begin compared++; mismatched++; $display("FAIL ext_timeout: results %0d required 1", got_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      compared++;
      if (g !== e) begin mismatched++; $display("FAIL ext_result: got %h required %h", g, e); end
`ifdef DPE_SAT_EN
      compared++;
      if (g[0 +: ODATAW] !== 20'h7FFFF) begin mismatched++; $display("FAIL ext_clamp: got %h required 7ffff", g[0 +: ODATAW]); end
      compared++;
      if (g[BATCH*ODATAW +: BATCH] !== {BATCH{1'b1}}) begin mismatched++; $display("FAIL ext_sat: got %b required all 1", g[BATCH*ODATAW +: BATCH]); end
`else
      compared++;
      if (g[0 +: ODATAW] !== 20'h80000) begin mismatched++; $display("FAIL ext_wrap: got %h required 80000", g[0 +: ODATAW]); end
`endif
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_reset_mid();
    bit ok; logic [RW-1:0] e, g;
    fill(1); drive_beat(1'b1, 1'b0); drive_beat(1'b1, 1'b0);
    drive_beat(1'b0, 1'b0); drive_beat(1'b0, 1'b0);
    apply_reset();
    compared++;
    if (bus.o_valid !== 1'b0) begin mismatched++; $display("FAIL rmid_o_valid: got %b required 0", bus.o_valid); end
    compared++;
    if (bus.i_ready !== 1'b1) begin mismatched++; $display("FAIL rmid_i_ready: got %b required 1", bus.i_ready); end
    fill(1); drive_beat(1'b0, 1'b1);
    wait_got(1, ok);
    if (!ok) begin compared++; mismatched++; $display("FAIL rmid_timeout0: results %0d required 1", got_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      compared++;
      if (g !== e) begin mismatched++; $display("FAIL rmid_empty_bank: got %h required %h", g, e); end
      compared++;
      if (g[BATCH*ODATAW-1:0] !== '0) begin mismatched++; $display("FAIL rmid_zero: got %h required 0", g[BATCH*ODATAW-1:0]); end
    end
    fill(1); drive_beat(1'b1, 1'b0); drive_beat(1'b1, 1'b0);
    drive_beat(1'b0, 1'b1);
    wait_got(1, ok);
    if (!ok) begin compared++; mismatched++; $display("FAIL rmid_timeout1: results %0d required 1", got_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      compared++;
      if (g !== e) begin mismatched++; $display("FAIL rmid_result: got %h required %h", g, e); end
      compared++;
      if (g[0 +: ODATAW] !== ODATAW'(16)) begin mismatched++; $display("FAIL rmid_sixteen: got %0d required 16", g[0 +: ODATAW]); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  initial begin
    test_reset();
    test_load();
    test_multi_beat();
    test_backpressure();
    test_interleave();
    test_extremes();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
